// File: rtl/lw_sw_multicycle_ctrl_pkg.sv
// Shared definitions for the load/store-word multicycle controller:
// state encodings, opcode/funct3 constants, mux-select codes and decode helpers.
package lw_sw_multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH    = 3'd0,
        S_DECODE   = 3'd1,
        S_MEMADR   = 3'd2,
        S_MEMREAD  = 3'd3,
        S_MEMWB    = 3'd4,
        S_MEMWRITE = 3'd5,
        S_HALT     = 3'd6
    } state_t;

    localparam logic [6:0] OPC_LW   = 7'b0000011;
    localparam logic [6:0] OPC_SW   = 7'b0100011;
    localparam logic [2:0] FUNCT3_W = 3'b010;

    localparam logic       ADR_PC      = 1'b0;
    localparam logic       ADR_ALU     = 1'b1;
    localparam logic       IMM_I       = 1'b0;
    localparam logic       IMM_S       = 1'b1;
    localparam logic [1:0] SRCA_PC     = 2'b00;
    localparam logic [1:0] SRCA_RS1    = 2'b10;
    localparam logic [1:0] SRCB_IMM    = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;
    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALURES  = 2'b10;

    function automatic logic is_lw_f(input logic [6:0] opcode, input logic [2:0] funct3);
        return (opcode == OPC_LW) && (funct3 == FUNCT3_W);
    endfunction

    function automatic logic is_sw_f(input logic [6:0] opcode, input logic [2:0] funct3);
        return (opcode == OPC_SW) && (funct3 == FUNCT3_W);
    endfunction

    // States in which the controller waits on the memory handshake
    function automatic logic is_mem_state_f(input state_t s);
        return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
    endfunction

endpackage

// File: rtl/lw_sw_multicycle_ctrl_if.sv
// Control/handshake bundle between the multicycle controller (master) and
// the datapath + memory side (slave).
interface lw_sw_multicycle_ctrl_if;
    logic [31:0] Instr;
    logic        mem_ready;
    logic        mem_req;
    logic        AdrSrc;
    logic        IRWrite;
    logic        PCWrite;
    logic        ImmSrc;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [2:0]  ALUControl;
    logic [1:0]  ResultSrc;
    logic        MemWrite;
    logic        RegWrite;
    logic        illegal;
    logic        timeout;
    logic [31:0] instr_count;

    modport master (
        input  Instr, mem_ready,
        output mem_req, AdrSrc, IRWrite, PCWrite, ImmSrc, ALUSrcA, ALUSrcB,
               ALUControl, ResultSrc, MemWrite, RegWrite, illegal, timeout, instr_count
    );

    modport slave (
        output Instr, mem_ready,
        input  mem_req, AdrSrc, IRWrite, PCWrite, ImmSrc, ALUSrcA, ALUSrcB,
               ALUControl, ResultSrc, MemWrite, RegWrite, illegal, timeout, instr_count
    );
endinterface

// File: rtl/lw_sw_multicycle_ctrl_mem_wait_timer.sv
// Counts consecutive mem_ready-low cycles within one memory state.
// expired is asserted combinationally on the WAIT_TIMEOUT-th low cycle;
// WAIT_TIMEOUT = 0 disables expiry entirely.
module mem_wait_timer #(
    parameter int unsigned WAIT_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int unsigned    CW   = (WAIT_TIMEOUT > 32'd1) ? $clog2(WAIT_TIMEOUT) : 1;
    localparam logic [CW-1:0]  LAST = (WAIT_TIMEOUT == 32'd0) ? {CW{1'b0}} : CW'(WAIT_TIMEOUT - 32'd1);
    localparam logic [CW-1:0]  ONE  = CW'(1'b1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count: clear on state change, saturate at the last allowed value
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {CW{1'b0}};
        end else if (en && (cnt_q != LAST)) begin
            cnt_d = cnt_q + ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Wait counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (WAIT_TIMEOUT != 32'd0) && en && (cnt_q == LAST);

endmodule

// File: rtl/lw_sw_multicycle_ctrl.sv
// Multicycle control FSM for the lw/sw datapath. Drives all mux selects and
// write strobes from the state register, handshakes with variable-latency
// memory, and halts on an illegal instruction or a memory wait timeout.
// Optional retired-instruction counter enabled by defining INSTR_COUNT_EN.
module lw_sw_multicycle_ctrl
    import lw_sw_multicycle_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_TIMEOUT = 15,
    parameter logic [2:0]  ALU_ADD      = 3'b000
) (
    input  logic                      clk,
    input  logic                      rst,
    lw_sw_multicycle_ctrl_if.master   bus
);
    state_t state_q, state_d;
    logic   illegal_q, illegal_d;
    logic   timeout_q, timeout_d;
    logic   is_lw_s, is_sw_s;
    logic   wait_en_s, wait_clr_s, wait_expired_s;
    logic   mem_req_s, adr_src_s, ir_write_s, pc_write_s, imm_src_s;
    logic   mem_write_s, reg_write_s;
    logic [1:0] alu_src_a_s, alu_src_b_s, result_src_s;
    logic [2:0] alu_control_s;
    logic   unused_instr_bits_s;

    assign is_lw_s = is_lw_f(bus.Instr[6:0], bus.Instr[14:12]);
    assign is_sw_s = is_sw_f(bus.Instr[6:0], bus.Instr[14:12]);
    assign unused_instr_bits_s = ^{bus.Instr[31:15], bus.Instr[11:7]};

    // The wait counter only runs in memory states and restarts on every state change
    assign wait_en_s  = is_mem_state_f(state_q) && !bus.mem_ready;
    assign wait_clr_s = (state_d != state_q);

    mem_wait_timer #(.WAIT_TIMEOUT(WAIT_TIMEOUT)) u_wait (
        .clk     (clk),
        .rst     (rst),
        .clr     (wait_clr_s),
        .en      (wait_en_s),
        .expired (wait_expired_s)
    );

    // Next-state and sticky-flag logic
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        timeout_d = timeout_q;
        case (state_q)
            S_FETCH: begin
                if (bus.mem_ready) begin
                    state_d = S_DECODE;
                end else if (wait_expired_s) begin
                    state_d   = S_HALT;
                    timeout_d = 1'b1;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                if (is_lw_s || is_sw_s) begin
                    state_d = S_MEMADR;
                end else begin
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
                end
            end
            S_MEMADR: begin
                if (is_sw_s) begin
                    state_d = S_MEMWRITE;
                end else begin
                    state_d = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                if (bus.mem_ready) begin
                    state_d = S_MEMWB;
                end else if (wait_expired_s) begin
                    state_d   = S_HALT;
                    timeout_d = 1'b1;
                end else begin
                    state_d = S_MEMREAD;
                end
            end
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWRITE: begin
                if (bus.mem_ready) begin
                    state_d = S_FETCH;
                end else if (wait_expired_s) begin
                    state_d   = S_HALT;
                    timeout_d = 1'b1;
                end else begin
                    state_d = S_MEMWRITE;
                end
            end
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_HALT;
        endcase
    end

    // State and sticky flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    // Per-state selects and strobes, blanked while rst is held
    always_comb begin
        mem_req_s     = 1'b0;
        adr_src_s     = ADR_PC;
        ir_write_s    = 1'b0;
        pc_write_s    = 1'b0;
        imm_src_s     = IMM_I;
        alu_src_a_s   = SRCA_PC;
        alu_src_b_s   = 2'b00;
        alu_control_s = 3'b000;
        result_src_s  = RES_ALUOUT;
        mem_write_s   = 1'b0;
        reg_write_s   = 1'b0;
        if (rst) begin
            mem_req_s = 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    mem_req_s     = 1'b1;
                    adr_src_s     = ADR_PC;
                    alu_src_a_s   = SRCA_PC;
                    alu_src_b_s   = SRCB_FOUR;
                    alu_control_s = ALU_ADD;
                    result_src_s  = RES_ALURES;
                    ir_write_s    = bus.mem_ready;
                    pc_write_s    = bus.mem_ready;
                end
                S_DECODE: imm_src_s = is_sw_s ? IMM_S : IMM_I;
                S_MEMADR: begin
                    alu_src_a_s   = SRCA_RS1;
                    alu_src_b_s   = SRCB_IMM;
                    alu_control_s = ALU_ADD;
                    imm_src_s     = is_sw_s ? IMM_S : IMM_I;
                end
                S_MEMREAD: begin
                    mem_req_s = 1'b1;
                    adr_src_s = ADR_ALU;
                end
                S_MEMWB: begin
                    result_src_s = RES_MEMDATA;
                    reg_write_s  = 1'b1;
                end
                S_MEMWRITE: begin
                    mem_req_s   = 1'b1;
                    adr_src_s   = ADR_ALU;
                    mem_write_s = 1'b1;
                end
                default: mem_req_s = 1'b0;
            endcase
        end
    end

    assign bus.mem_req    = mem_req_s;
    assign bus.AdrSrc     = adr_src_s;
    assign bus.IRWrite    = ir_write_s;
    assign bus.PCWrite    = pc_write_s;
    assign bus.ImmSrc     = imm_src_s;
    assign bus.ALUSrcA    = alu_src_a_s;
    assign bus.ALUSrcB    = alu_src_b_s;
    assign bus.ALUControl = alu_control_s;
    assign bus.ResultSrc  = result_src_s;
    assign bus.MemWrite   = mem_write_s;
    assign bus.RegWrite   = reg_write_s;
    assign bus.illegal    = rst ? 1'b0 : illegal_q;
    assign bus.timeout    = rst ? 1'b0 : timeout_q;

`ifdef INSTR_COUNT_EN
    logic [31:0] instr_count_q, instr_count_d;

    // One count per retirement (load write-back or accepted store), wrapping at 32 bits
    always_comb begin
        if ((state_q == S_MEMWB) || ((state_q == S_MEMWRITE) && bus.mem_ready)) begin
            instr_count_d = instr_count_q + 32'd1;
        end else begin
            instr_count_d = instr_count_q;
        end
    end

    // Retired-instruction counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_count_q <= 32'd0;
        end else begin
            instr_count_q <= instr_count_d;
        end
    end

    assign bus.instr_count = rst ? 32'd0 : instr_count_q;
`else
    assign bus.instr_count = 32'd0;
`endif

endmodule
